// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-requester data-memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_pick.sv
// 2-way round-robin picker: combinational, one-hot winner from request bits and last-served id.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] win,
  output logic       any
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = (last == REQ_CPU) ? 2'b10 : 2'b01;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_arbiter.sv
// CPU/loader data-memory arbiter: Gnt at +1, Rvalid at +2; requesters hold Req until Gnt.
// Optional MEM_ARB_LOCK_EN adds a Lock input letting the last-served requester keep the memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
`ifdef MEM_ARB_LOCK_EN
  input  logic [1:0]        Lock,
`endif
  input  logic [1:0]        Req,
  input  logic [1:0]        Wr,
  input  logic [2*AW-1:0]   Addr,
  input  logic [2*DW-1:0]   Wdata,
  output logic [1:0]        Gnt,
  output logic [1:0]        Rvalid,
  output logic [DW-1:0]     Rdata,
  output logic [AW-1:0]     D_Addr,
  output logic              D_Wr,
  output logic [DW-1:0]     D_Wdata,
  input  logic [DW-1:0]     D_Rdata,
  output logic              Busy
);

  state_t     state_q, state_d;
  req_id_t    last_q, cur_q, win_id;
  logic [1:0] last_oh, cur_oh, pick_req, win;
  logic       any_req;

  assign last_oh = (last_q == REQ_LDR) ? 2'b10 : 2'b01;
  assign cur_oh  = (cur_q  == REQ_LDR) ? 2'b10 : 2'b01;

`ifdef MEM_ARB_LOCK_EN
  // A locked last-served requester that is still asking overrides round-robin.
  logic lock_hit;
  assign lock_hit = |(Lock & Req & last_oh);
  assign pick_req = lock_hit ? last_oh : Req;
`else
  assign pick_req = Req;
`endif

  rr_pick u_pick (
    .req  (pick_req),
    .last (last_q),
    .win  (win),
    .any  (any_req)
  );

  assign win_id = win[1] ? REQ_LDR : REQ_CPU;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      last_q  <= REQ_LDR;
      cur_q   <= REQ_CPU;
      D_Addr  <= '0;
      D_Wr    <= 1'b0;
      D_Wdata <= '0;
    end else begin
      state_q <= state_d;
      D_Wr    <= 1'b0;
      if (state_q == IDLE && any_req) begin
        cur_q   <= win_id;
        last_q  <= win_id;
        D_Addr  <= win[1] ? Addr[2*AW-1:AW]   : Addr[AW-1:0];
        D_Wdata <= win[1] ? Wdata[2*DW-1:DW]  : Wdata[DW-1:0];
        D_Wr    <= win[1] ? Wr[1]             : Wr[0];
      end
    end
  end

  // D_Wr is only ever high during ACCESS, so it doubles as the write flag there.
  always_comb begin
    state_d = state_q;
    Gnt     = 2'b00;
    Rvalid  = 2'b00;
    Rdata   = '0;
    Busy    = 1'b1;
    case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (any_req) state_d = ACCESS;
      end
      ACCESS: begin
        Gnt     = cur_oh;
        state_d = D_Wr ? IDLE : RDATA;
      end
      RDATA: begin
        Rvalid  = cur_oh;
        Rdata   = D_Rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/reads, a negedge monitor checks them.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic            Clk = 1'b0;
  logic            Rst_n = 1'b0;
  logic [1:0]      Req = 2'b00;
  logic [1:0]      Wr = 2'b00;
  logic [2*AW-1:0] Addr = '0;
  logic [2*DW-1:0] Wdata = '0;
`ifdef MEM_ARB_LOCK_EN
  logic [1:0]      Lock = 2'b00;
`endif
  logic [1:0]      Gnt, Rvalid;
  logic [DW-1:0]   Rdata, D_Wdata;
  logic [DW-1:0]   D_Rdata = '0;
  logic [AW-1:0]   D_Addr;
  logic            D_Wr, Busy;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
`ifdef MEM_ARB_LOCK_EN
    .Lock    (Lock),
`endif
    .Req     (Req),
    .Wr      (Wr),
    .Addr    (Addr),
    .Wdata   (Wdata),
    .Gnt     (Gnt),
    .Rvalid  (Rvalid),
    .Rdata   (Rdata),
    .D_Addr  (D_Addr),
    .D_Wr    (D_Wr),
    .D_Wdata (D_Wdata),
    .D_Rdata (D_Rdata),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge Clk) begin
    if (D_Wr) mem[D_Addr] <= D_Wdata;
    D_Rdata <= mem[D_Addr];
  end

  typedef struct {
    logic [1:0]    gnt;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    int            cyc;
  } gexp_t;

  typedef struct {
    logic [1:0]    rv;
    logic [DW-1:0] rdata;
    int            cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t mg;
  rexp_t mr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (Gnt != 2'b00) begin
        if (gq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_gnt: got %b, expected none (cycle %0d)", Gnt, cyc);
        end else begin
          mg = gq.pop_front();
          chk("gnt",       32'(Gnt),     32'(mg.gnt));
          chk("gnt_cycle", 32'(cyc),     32'(mg.cyc));
          chk("d_addr",    32'(D_Addr),  32'(mg.addr));
          chk("d_wr",      32'(D_Wr),    32'(mg.wr));
          chk("d_wdata",   32'(D_Wdata), 32'(mg.wdata));
        end
      end else begin
        chk("d_wr_outside_access", 32'(D_Wr), 32'd0);
      end
      if (Rvalid != 2'b00) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got %b, expected none (cycle %0d)", Rvalid, cyc);
        end else begin
          mr = rq.pop_front();
          chk("rvalid",       32'(Rvalid), 32'(mr.rv));
          chk("rvalid_cycle", 32'(cyc),    32'(mr.cyc));
          chk("rdata",        32'(Rdata),  32'(mr.rdata));
        end
      end else begin
        chk("rdata_outside_rdata", 32'(Rdata), 32'd0);
      end
    end
  end

  task automatic push_g(input logic [1:0] g, input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] wd, input int c);
    gexp_t e;
    e.gnt = g; e.addr = a; e.wr = w; e.wdata = wd; e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic push_r(input logic [1:0] v, input logic [DW-1:0] d, input int c);
    rexp_t e;
    e.rv = v; e.rdata = d; e.cyc = c;
    rq.push_back(e);
  endtask

  task automatic wait_idle();
    logic idle = 1'b0;
    repeat (10) if (!idle) begin
      @(negedge Clk);
      idle = !Busy;
    end
    chk("idle_timeout", 32'(idle), 32'd1);
  endtask

  // Single access by one requester; called at a negedge with the arbiter idle.
  task automatic issue(input int idx, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] erd);
    logic got = 1'b0;
    Addr[idx*AW +: AW]  = a;
    Wdata[idx*DW +: DW] = wd;
    Wr[idx]  = w;
    Req[idx] = 1'b1;
    push_g(2'b01 << idx, a, w, wd, cyc + 1);
    if (!w) push_r(2'b01 << idx, erd, cyc + 2);
    repeat (10) if (!got) begin
      @(negedge Clk);
      got = Gnt[idx];
    end
    chk("gnt_timeout", 32'(got), 32'd1);
    Req[idx] = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},     32'(Gnt),     32'd0);
    chk({tag, "_rvalid"},  32'(Rvalid),  32'd0);
    chk({tag, "_rdata"},   32'(Rdata),   32'd0);
    chk({tag, "_d_wr"},    32'(D_Wr),    32'd0);
    chk({tag, "_d_addr"},  32'(D_Addr),  32'd0);
    chk({tag, "_d_wdata"}, 32'(D_Wdata), 32'd0);
    chk({tag, "_busy"},    32'(Busy),    32'd0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    Rst_n = 1'b1;
    @(negedge Clk);

    // Single-requester traffic: write then read back from the other side.
    issue(0, 1'b1, 8'h10, 16'h1234, 16'h0000);
    issue(1, 1'b0, 8'h10, 16'hBEEF, 16'h1234);
    issue(0, 1'b0, 8'h10, 16'h0F0F, 16'h1234);
    issue(1, 1'b1, 8'h20, 16'h5678, 16'h0000);
    issue(0, 1'b0, 8'h20, 16'h0000, 16'h5678);

    // Both requesting writes from reset: CPU, LDR, CPU, LDR.
    do_reset();
    Addr  = {8'h31, 8'h30};
    Wdata = {16'h2222, 16'h1111};
    Wr    = 2'b11;
    n = cyc;
    push_g(2'b01, 8'h30, 1'b1, 16'h1111, n + 1);
    push_g(2'b10, 8'h31, 1'b1, 16'h2222, n + 3);
    push_g(2'b01, 8'h30, 1'b1, 16'h1111, n + 5);
    push_g(2'b10, 8'h31, 1'b1, 16'h2222, n + 7);
    Req = 2'b11;
    repeat (7) @(negedge Clk);
    Req = 2'b00;
    wait_idle();

    // Both requesting reads: 3-cycle spacing, CPU first since LDR was last served.
    Wr = 2'b00;
    n = cyc;
    push_g(2'b01, 8'h30, 1'b0, 16'h1111, n + 1);
    push_r(2'b01, 16'h1111, n + 2);
    push_g(2'b10, 8'h31, 1'b0, 16'h2222, n + 4);
    push_r(2'b10, 16'h2222, n + 5);
    Req = 2'b11;
    repeat (4) @(negedge Clk);
    Req = 2'b00;
    wait_idle();

    // Reset pulsed during RDATA aborts the read.
    Addr[AW +: AW] = 8'h10;
    Wr[1] = 1'b0;
    push_g(2'b10, 8'h10, 1'b0, 16'h2222, cyc + 1);
    Req = 2'b10;
    @(negedge Clk);
    Req = 2'b00;
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1 check_reset_outputs("rst_in_rdata");
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);

`ifdef MEM_ARB_LOCK_EN
    // Locked loader keeps winning; unlocking resumes alternation with the CPU.
    Addr  = {8'h41, 8'h40};
    Wdata = {16'hB0B0, 16'hA0A0};
    Wr    = 2'b11;
    Lock  = 2'b10;
    n = cyc;
    push_g(2'b10, 8'h41, 1'b1, 16'hB0B0, n + 1);
    push_g(2'b10, 8'h41, 1'b1, 16'hB0B0, n + 3);
    push_g(2'b10, 8'h41, 1'b1, 16'hB0B0, n + 5);
    push_g(2'b01, 8'h40, 1'b1, 16'hA0A0, n + 7);
    Req = 2'b11;
    repeat (5) @(negedge Clk);
    Lock = 2'b00;
    repeat (2) @(negedge Clk);
    Req = 2'b00;
    wait_idle();
`endif

    repeat (3) @(negedge Clk);
    chk("grants_outstanding", 32'(gq.size()), 32'd0);
    chk("reads_outstanding",  32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
